output_port_allocator: RTL
==========================

# output_port_allocator

Per-output-port switch allocator for the 5-port NoC router (N, S, W, E, L). It picks one input among those whose next-hop address matches this output port, using a rotating round-robin pointer. The grant is held for a whole packet, head flit through tail flit, in wormhole fashion. The block gates each flit on downstream credits, drives the crossbar select and input-buffer pops, and pulses a rotate strobe at each packet end so the existing round-robin priority registers stay in step.

## Interface
Parameters:
- PORT_ID, 3'd4, port code this output serves; port codes are N=0, S=1, W=2, E=3, L=4.
- CREDITS, 4, downstream buffer depth (1..15).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low.
- req_valid_i  input  5  input i holds a flit; bit index = port code.
- nexthop_addr_i  input  15  packed; field i is [3i+2:3i], the next-hop port code of input i's flit.
- tail_i  input  5  flit at input i is a tail (a head that is also a tail is a single-flit packet).
- credit_return_i  input  1  downstream freed one slot this cycle.
- grant_o  output  5  one-hot current owner; 0 when idle.
- xbar_sel_o  output  3  owner port code; 3'd7 when idle.
- flit_valid_o  output  1  a flit crosses the switch this cycle.
- pop_o  output  5  grant_o & {5{flit_valid_o}}.
- credit_cnt_o  output  4  available downstream credits.
- change_order_o  output  1  one-cycle rotate pulse after each tail transfer.

## Operation
- eligible[i] = req_valid_i[i] && (nexthop_addr_i[i] == PORT_ID).
- FSM, two states:
  - IDLE: if any eligible, choose the first eligible input in the order ptr, ptr+1, … (mod 5), register it as owner, go to BUSY. Otherwise stay in IDLE.
  - BUSY: flit_valid_o = req_valid_i[owner] && credit_cnt_o != 0, computed combinationally from registered state.
    - On a transfer with tail_i[owner]=1: go to IDLE, set ptr = owner+1 mod 5, and set change_order_o for the next cycle.
- While in BUSY, eligibility of other inputs is ignored.
- Owner drops req_valid_i mid-packet: grant is held, no transfer, no timeout.
- Credit counter, evaluated each cycle:
  - transfer only: -1.
  - credit_return_i only: +1, except that a return while at CREDITS is ignored (saturates).
  - both in the same cycle: unchanged.
- A flit never transfers while credit_cnt_o = 0.
- Reset values: state=IDLE, ptr=0 (N first), grant_o=0, xbar_sel_o=7, flit_valid_o=0, pop_o=0, credit_cnt_o=CREDITS, change_order_o=0.
- Reset asserted mid-packet: all of the above apply immediately (asynchronously); the partial packet is abandoned.

## Timing
- Request to grant: eligible in cycle t (IDLE) gives grant_o in cycle t+1; the first flit can transfer in t+1.
- Each packet costs one bubble cycle (IDLE) between the tail transfer and the next grant.
- change_order_o is high in exactly the cycle after the tail transfer, i.e. the IDLE cycle.
- Credits: a credit_return_i in cycle t enables a transfer in cycle t+1 at the earliest.
- Sustained throughput is 1 flit/cycle while credits are nonzero.

## Structure
- noc_pkg holds:
  - port-code localparams: PORT_N/S/W/E/L = 0..4, NUM_PORTS=5, SEL_IDLE=3'd7.
  - the FSM enum {ALLOC_IDLE, ALLOC_BUSY}.
  - a next-hop field extraction function.
- Sub-module rr_pick5: combinational; inputs ptr[2:0] and eligible[4:0]; outputs one-hot pick[4:0], pick_code[2:0] and any_o.
- The top level holds the FSM, owner/ptr registers, credit counter and output muxing.

## Test plan
All scenarios use PORT_ID=4 and CREDITS=4.
- Reset: hold reset=0 for 3 cycles -> grant_o=0, xbar_sel_o=7, credit_cnt_o=4, flit_valid_o=0, change_order_o=0.
- Contention:
  - Stimulus: N and E both request with nexthop=4, 3-flit packets, from cycle 0, with credit_return_i pulsed every cycle.
  - Response: grant_o=5'b00001 in cycles 1-3, tail transfer in cycle 3, change_order_o=1 in cycle 4, grant_o=5'b01000 (E) in cycle 5.
- Credit stall:
  - Stimulus: S sends a 6-flit packet with no credit returns.
  - Response: 4 transfers, then flit_valid_o=0 with credit_cnt_o=0. A credit_return_i in cycle t gives exactly one pop_o[1] in cycle t+1.
- Simultaneous credit events: at credit_cnt_o=2, transfer and credit_return_i in the same cycle -> credit_cnt_o stays 2. A return at 4 -> stays 4.
- Address filter and hole:
  - W requests with nexthop=1 -> never granted.
  - Owner N deasserts req_valid_i for 2 cycles mid-packet -> grant_o held, pop_o=0, packet resumes.
- Reset mid-packet: reset=0 between flits 1 and 2 -> outputs return immediately to reset values; after release, arbitration restarts from N.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared port codes, allocator FSM encoding and next-hop field helpers
// for the 5-port NoC router.
package noc_pkg;

    localparam logic [2:0] PORT_N   = 3'd0;
    localparam logic [2:0] PORT_S   = 3'd1;
    localparam logic [2:0] PORT_W   = 3'd2;
    localparam logic [2:0] PORT_E   = 3'd3;
    localparam logic [2:0] PORT_L   = 3'd4;
    localparam int         NUM_PORTS = 5;
    localparam logic [2:0] SEL_IDLE = 3'd7;

    typedef enum logic {
        ALLOC_IDLE,
        ALLOC_BUSY
    } alloc_state_t;

    // Field i of the packed next-hop bus lives at [3i+2:3i].
    function automatic logic [2:0] nexthop_field(input logic [14:0] addr, input int port);
        return addr[3*port +: 3];
    endfunction

    // Successor port code in round-robin order; out-of-range codes wrap to N.
    function automatic logic [2:0] next_port(input logic [2:0] code);
        return (code >= PORT_L) ? PORT_N : code + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first eligible input in the order
// ptr, ptr+1, ... (mod 5), returned both one-hot and as a port code.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [2:0] ptr_i,
    input  logic [4:0] eligible_i,
    output logic [4:0] pick_o,
    output logic [2:0] pick_code_o,
    output logic       any_o
);

    always_comb begin : pick_search
        logic [2:0] v_idx;
        logic       v_found;
        // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latches).
        pick_o      = '0;
        pick_code_o = SEL_IDLE;
        any_o       = |eligible_i;
        v_found     = 1'b0;
        v_idx       = (ptr_i > PORT_L) ? PORT_N : ptr_i;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!v_found && eligible_i[v_idx]) begin
                pick_o[v_idx] = 1'b1;
                pick_code_o   = v_idx;
                v_found       = 1'b1;
            end
            v_idx = next_port(v_idx);
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole switch allocator for one router output: round-robin owner choice,
// packet-long grant hold, downstream credit gating and rotate strobe.
module output_port_allocator
    import noc_pkg::*;
#(
    parameter logic [2:0]  PORT_ID = 3'd4,
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  req_valid_i,
    input  logic [14:0] nexthop_addr_i,
    input  logic [4:0]  tail_i,
    input  logic        credit_return_i,
    output logic [4:0]  grant_o,
    output logic [2:0]  xbar_sel_o,
    output logic        flit_valid_o,
    output logic [4:0]  pop_o,
    output logic [3:0]  credit_cnt_o,
    output logic        change_order_o
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

    alloc_state_t r_state;
    alloc_state_t w_next_state;
    logic [2:0]   r_owner;
    logic [4:0]   r_grant;
    logic [2:0]   r_ptr;
    logic [3:0]   r_credit;
    logic         r_change_order;

    logic [4:0]   w_eligible;
    logic [4:0]   w_pick;
    logic [2:0]   w_pick_code;
    logic         w_any;
    logic         w_xfer;
    logic         w_tail_xfer;
    logic [3:0]   w_credit_next;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_eligible[i] = req_valid_i[i] && (nexthop_field(nexthop_addr_i, i) == PORT_ID);
        end
    end

    rr_pick5 u_rr_pick5 (
        .ptr_i       (r_ptr),
        .eligible_i  (w_eligible),
        .pick_o      (w_pick),
        .pick_code_o (w_pick_code),
        .any_o       (w_any)
    );

    assign w_xfer      = (r_state == ALLOC_BUSY) && req_valid_i[r_owner] && (r_credit != 4'd0);
    assign w_tail_xfer = w_xfer && tail_i[r_owner];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ALLOC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ALLOC_IDLE: if (w_any)       w_next_state = ALLOC_BUSY;
            ALLOC_BUSY: if (w_tail_xfer) w_next_state = ALLOC_IDLE;
            default:                     w_next_state = ALLOC_IDLE;
        endcase
    end

    always_comb begin
        grant_o      = '0;
        xbar_sel_o   = SEL_IDLE;
        flit_valid_o = 1'b0;
        if (r_state == ALLOC_BUSY) begin
            grant_o      = r_grant;
            xbar_sel_o   = r_owner;
            flit_valid_o = w_xfer;
        end
        pop_o = grant_o & {5{flit_valid_o}};
    end

    // Owner is latched once per packet; the pointer only moves at packet end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner        <= PORT_N;
            r_grant        <= '0;
            r_ptr          <= PORT_N;
            r_change_order <= 1'b0;
        end else begin
            r_change_order <= w_tail_xfer;
            if (r_state == ALLOC_IDLE && w_any) begin
                r_owner <= w_pick_code;
                r_grant <= w_pick;
            end else if (w_tail_xfer) begin
                r_grant <= '0;
                r_ptr   <= next_port(r_owner);
            end
        end
    end

    // A transfer and a return in the same cycle cancel; returns saturate at full.
    always_comb begin
        w_credit_next = r_credit;
        unique case ({w_xfer, credit_return_i})
            2'b10:   w_credit_next = r_credit - 4'd1;
            2'b01:   w_credit_next = (r_credit == CREDIT_MAX) ? r_credit : r_credit + 4'd1;
            default: w_credit_next = r_credit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit <= CREDIT_MAX;
        end else begin
            r_credit <= w_credit_next;
        end
    end

    assign credit_cnt_o   = r_credit;
    assign change_order_o = r_change_order;

endmodule
